// File: rtl/universal_shift_register.sv
// rtl/universal_shift_register.sv - universal shift register stepped by a debounced push button
// Define USR_ROTATE_EN to build rotate for mode=11; otherwise mode=11 holds.
module universal_shift_register #(
    parameter int WIDTH     = 8,
    parameter int DB_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic             Sin,
    input  logic [WIDTH-1:0] Pin,
    output logic             Sout,
    output logic [WIDTH-1:0] Pout,
    output logic             step
);
    // The counter only ever holds 0..DB_CYCLES-1; reaching the last value accepts the new level.
    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_SHIFT = 2'b01;
    localparam logic [1:0] MODE_LOAD  = 2'b10;
`ifdef USR_ROTATE_EN
    localparam logic [1:0] MODE_ROT   = 2'b11;
`endif

    logic             sync1_q;
    logic             sync2_q;
    logic             db_q;
    logic             db_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             step_q;
    logic             step_d;
    logic [WIDTH-1:0] reg_q;
    logic [WIDTH-1:0] reg_d;

    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        step_d = db_d & ~db_q;
    end

    always_comb begin
        reg_d = reg_q;
        if (step_q) begin
            case (mode)
                MODE_HOLD:  reg_d = reg_q;
                MODE_SHIFT: reg_d = dir ? {reg_q[WIDTH-2:0], Sin} : {Sin, reg_q[WIDTH-1:1]};
                MODE_LOAD:  reg_d = Pin;
`ifdef USR_ROTATE_EN
                MODE_ROT:   reg_d = dir ? {reg_q[WIDTH-2:0], reg_q[WIDTH-1]}
                                        : {reg_q[0], reg_q[WIDTH-1:1]};
`endif
                default:    reg_d = reg_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
            step_q  <= 1'b0;
            reg_q   <= '0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            reg_q   <= reg_d;
        end
    end

    assign Pout = reg_q;
    assign step = step_q;
    assign Sout = dir ? reg_q[WIDTH-1] : reg_q[0];

endmodule

// File: tb/tb_universal_shift_register.sv
// tb/tb_universal_shift_register.sv - self-checking bench for universal_shift_register
module tb_universal_shift_register;
    localparam int W  = 8;
    localparam int DB = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         btn = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic         dir = 1'b0;
    logic         Sin = 1'b0;
    logic [W-1:0] Pin = '0;
    logic         Sout;
    logic [W-1:0] Pout;
    logic         step;

    int tests = 0;
    int fails = 0;
    int lat;
    int nsteps;

    logic [W-1:0] m_reg;
    bit           m_db;
    bit           m_step;
    bit           pipe[$];
    bit           hist[$];

    universal_shift_register #(.WIDTH(W), .DB_CYCLES(DB)) dut (
        .clk  (clk),
        .reset(reset),
        .btn  (btn),
        .mode (mode),
        .dir  (dir),
        .Sin  (Sin),
        .Pin  (Pin),
        .Sout (Sout),
        .Pout (Pout),
        .step (step)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] next_reg(input logic [1:0] md, input logic dr,
                                              input logic si, input logic [W-1:0] pin,
                                              input logic [W-1:0] cur);
        int unsigned v;
        int unsigned mask;
        int unsigned s;
        v    = cur;
        mask = (1 << W) - 1;
        s    = si;
        case (md)
            2'd1: v = dr ? (((v << 1) | s) & mask) : ((v >> 1) | (s << (W - 1)));
            2'd2: v = pin;
`ifdef USR_ROTATE_EN
            2'd3: v = dr ? (((v << 1) | (v >> (W - 1))) & mask) : ((v >> 1) | ((v & 1) << (W - 1)));
`endif
            default: v = cur;
        endcase
        return v[W-1:0];
    endfunction

    task automatic model_clear();
        m_reg  = '0;
        m_db   = 1'b0;
        m_step = 1'b0;
        pipe.delete();
        pipe.push_back(1'b0);
        pipe.push_back(1'b0);
        hist.delete();
    endtask

    // Button level seen by the debouncer is btn from two edges earlier; a flip needs the last DB samples all opposite db.
    task automatic model_edge();
        bit s2;
        bit flip;
        if (reset) begin
            model_clear();
            return;
        end
        if (m_step) m_reg = next_reg(mode, dir, Sin, Pin, m_reg);
        s2 = pipe.pop_front();
        pipe.push_back(btn);
        hist.push_back(s2);
        if (hist.size() > DB) void'(hist.pop_front());
        flip = (hist.size() == DB);
        foreach (hist[i]) if (hist[i] == m_db) flip = 1'b0;
        m_step = 1'b0;
        if (flip) begin
            m_db   = !m_db;
            m_step = m_db;
        end
    endtask

    task automatic check_all();
        chk("pout", Pout, m_reg);
        chk("step", step, m_step);
        chk("sout", Sout, dir ? m_reg[W-1] : m_reg[0]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic press(input int hold, input int rel);
        btn = 1'b1;
        for (int i = 0; i < hold; i++) tick();
        btn = 1'b0;
        for (int i = 0; i < rel; i++) tick();
    endtask

    initial begin
        model_clear();
        @(negedge clk);

        // Reset with the button held and load data present
        reset = 1'b1; btn = 1'b1; Pin = 8'hA5; mode = 2'b10;
        model_clear();
        #1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst_pout", Pout, 8'h00);
            chk("rst_step", step, 1'b0);
            chk("rst_sout", Sout, 1'b0);
        end
        btn = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) tick();

        // Parallel load from a clean 20-cycle press
        mode = 2'b10; Pin = 8'h3C; btn = 1'b1;
        lat = 0; nsteps = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (step === 1'b1) begin
                nsteps++;
                if (lat == 0) lat = i;
            end
        end
        chk("press_latency", lat, DB + 2);
        chk("held_one_step", nsteps, 1);
        chk("load_3c", Pout, 8'h3C);
        btn = 1'b0;
        for (int i = 0; i < DB + 4; i++) tick();

        // Shift right three times from 8'h81
        Pin = 8'h81;
        press(8, 8);
        chk("load_81", Pout, 8'h81);
        mode = 2'b01; dir = 1'b0; Sin = 1'b0;
        #1 chk("sout_pre", Sout, 1'b1);
        press(8, 8);
        chk("shr_1", Pout, 8'h40);
        chk("sout_1", Sout, 1'b0);
        press(8, 8);
        chk("shr_2", Pout, 8'h20);
        press(8, 8);
        chk("shr_3", Pout, 8'h10);
        chk("sout_3", Sout, 1'b0);

        // Bouncing button never stays stable long enough
        nsteps = 0;
        for (int i = 0; i < 30; i++) begin
            btn = ((i / 2) % 2) == 1;
            tick();
            if (step === 1'b1) nsteps++;
        end
        btn = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (step === 1'b1) nsteps++;
        end
        chk("bounce_no_step", nsteps, 0);
        chk("bounce_pout", Pout, 8'h10);

        // mode=11 with dir=1 from 8'h81
        mode = 2'b10; Pin = 8'h81;
        press(8, 8);
        mode = 2'b11; dir = 1'b1; Sin = 1'b1;
        press(8, 8);
`ifdef USR_ROTATE_EN
        chk("mode11", Pout, 8'h03);
`else
        chk("mode11", Pout, 8'h81);
`endif

        // Reset asserted between edges clears the register immediately
        #2 reset = 1'b1;
        model_clear();
        #1;
        chk("async_pout", Pout, 8'h00);
        chk("async_sout", Sout, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        // Reset two cycles into a held press restarts the debounce
        mode = 2'b10; Pin = 8'h5A; btn = 1'b1;
        nsteps = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (step === 1'b1) nsteps++;
        end
        reset = 1'b1;
        model_clear();
        for (int i = 0; i < 2; i++) begin
            tick();
            if (step === 1'b1) nsteps++;
        end
        chk("pre_reset_no_step", nsteps, 0);
        reset = 1'b0;
        lat = 0; nsteps = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (step === 1'b1) begin
                nsteps++;
                if (lat == 0) lat = i;
            end
        end
        chk("post_reset_latency", lat, DB + 2);
        chk("post_reset_one_step", nsteps, 1);
        chk("post_reset_load", Pout, 8'h5A);
        btn = 1'b0;
        for (int i = 0; i < DB + 4; i++) tick();

        // Randomized button activity with random controls
        for (int n = 0; n < 300; n++) begin
            btn  = 1'($urandom_range(0, 1));
            mode = 2'($urandom_range(0, 3));
            dir  = 1'($urandom_range(0, 1));
            Sin  = 1'($urandom_range(0, 1));
            Pin  = 8'($urandom);
            for (int i = 0; i < int'($urandom_range(1, 8)); i++) tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
